// File: rtl/avg_seq_ctrl.sv
// Sequencing controller for a growing-block averager: gates samples into
// 2^n blocks, applies config only at block boundaries, and buffers one result.
module avg_seq_ctrl #(
    parameter int N      = 16,
    parameter int MAXLOG = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        cfg_n_avgs,
    input  logic              cfg_wr,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    output logic              avg_valid,
    output logic [N-1:0]      avg_x,
    output logic [2:0]        avg_n_avgs,
    input  logic              avg_new_dat,
    input  logic [N-1:0]      avg_y,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [15:0]       blk_cnt,
    output logic              ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [MAXLOG:0] ONE_L = {{MAXLOG{1'b0}}, 1'b1};

    // A zero length request is treated as the shortest legal block (2 samples).
    function automatic logic [2:0] clamp_n(input logic [2:0] v);
        return (v == 3'd0) ? 3'd1 : v;
    endfunction

    state_e              state_q, state_d;
    logic [MAXLOG-1:0]   cnt_q, cnt_d;
    logic [15:0]         blk_q, blk_d;
    logic [2:0]          n_q, n_d;
    logic [2:0]          pend_n_q, pend_n_d;
    logic                pend_v_q, pend_v_d;
    logic                avg_valid_q, avg_valid_d;
    logic [N-1:0]        avg_x_q, avg_x_d;
    logic                out_valid_q, out_valid_d;
    logic [N-1:0]        out_data_q, out_data_d;
    logic                ovf_q, ovf_d;

    logic                accept_s;
    logic                start_idle_s;
    logic                wrap_s;
    logic                boundary_s;
    logic [MAXLOG:0]     len_m1_s;
    logic                cand_v_s;
    logic [2:0]          cand_n_s;

    // Next-state logic for the FSM, counters, config staging and result buffer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        n_d         = n_q;
        pend_n_d    = pend_n_q;
        pend_v_d    = pend_v_q;
        avg_valid_d = 1'b0;
        avg_x_d     = avg_x_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;

        accept_s     = in_valid && (state_q != ST_IDLE);
        start_idle_s = start && (state_q == ST_IDLE);
        len_m1_s     = (ONE_L << n_q) - ONE_L;
        wrap_s       = accept_s && ({1'b0, cnt_q} == len_m1_s);
        // A boundary is either the wrap edge or an idle slot before a block starts.
        boundary_s   = wrap_s || ((cnt_q == {MAXLOG{1'b0}}) && !accept_s);
        cand_v_s     = cfg_wr || pend_v_q;
        cand_n_s     = cfg_wr ? clamp_n(cfg_n_avgs) : pend_n_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    if ((cnt_q == {MAXLOG{1'b0}}) && !accept_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (wrap_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_idle_s) begin
            cnt_d = {MAXLOG{1'b0}};
            blk_d = 16'd0;
        end else if (accept_s) begin
            if (wrap_s) begin
                cnt_d = {MAXLOG{1'b0}};
                blk_d = blk_q + 16'd1;
            end else begin
                cnt_d = cnt_q + {{(MAXLOG-1){1'b0}}, 1'b1};
                blk_d = blk_q;
            end
        end else begin
            cnt_d = cnt_q;
            blk_d = blk_q;
        end

        if (cand_v_s && boundary_s) begin
            n_d      = cand_n_s;
            pend_v_d = 1'b0;
        end else if (cfg_wr) begin
            pend_n_d = clamp_n(cfg_n_avgs);
            pend_v_d = 1'b1;
        end else begin
            pend_v_d = pend_v_q;
        end

        if (accept_s) begin
            avg_valid_d = 1'b1;
            avg_x_d     = in_data;
        end else begin
            avg_valid_d = 1'b0;
        end

        if (start_idle_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // One-entry buffer: a held, unaccepted result blocks the new one.
        if (avg_new_dat) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = avg_y;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {MAXLOG{1'b0}};
            blk_q       <= 16'd0;
            n_q         <= 3'd1;
            pend_n_q    <= 3'd0;
            pend_v_q    <= 1'b0;
            avg_valid_q <= 1'b0;
            avg_x_q     <= {N{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {N{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            n_q         <= n_d;
            pend_n_q    <= pend_n_d;
            pend_v_q    <= pend_v_d;
            avg_valid_q <= avg_valid_d;
            avg_x_q     <= avg_x_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign avg_valid  = avg_valid_q;
    assign avg_x      = avg_x_q;
    assign avg_n_avgs = n_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign blk_cnt    = blk_q;
    assign ovf        = ovf_q;

endmodule

// File: doc/avg_seq_ctrl.md
AVG_SEQ_CTRL -- requirements
Module: avg_seq_ctrl

Interface
REQ-001 Parameter N, 16: sample and result data width in bits.
REQ-002 Parameter MAXLOG, 7: maximum log2 block length; the averaging config field is 3 bits wide.
REQ-003 clk  in  1  single clock; all logic updates on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 cfg_n_avgs  in  3  requested log2 averaging length n.
REQ-006 cfg_wr  in  1  one-cycle pulse that latches cfg_n_avgs as the pending config.
REQ-007 start  in  1  one-cycle pulse; begins a run.
REQ-008 stop  in  1  one-cycle pulse; requests an end of run at the next block boundary.
REQ-009 in_valid  in  1  upstream sample strobe.
REQ-010 in_data  in  N  upstream sample.
REQ-011 avg_valid  out  1  sample strobe to the growing averager.
REQ-012 avg_x  out  N  sample to the growing averager.
REQ-013 avg_n_avgs  out  3  active n driven to the averager.
REQ-014 avg_new_dat  in  1  averager result-ready strobe.
REQ-015 avg_y  in  N  averager result.
REQ-016 out_valid  out  1  result available downstream.
REQ-017 out_data  out  N  held result.
REQ-018 out_ready  in  1  downstream accepts the result.
REQ-019 busy  out  1  high when the state is not IDLE.
REQ-020 blk_cnt  out  16  number of completed input blocks in the current run, wrapping.
REQ-021 ovf  out  1  sticky flag: a result was lost.

Function
REQ-022 States are IDLE, RUN and DRAIN; the state register is reset to IDLE.
REQ-023 IDLE -> RUN on start when stop is low; start and stop together in IDLE leave the state in IDLE.
REQ-024 start in IDLE clears blk_cnt, the sample counter and ovf.
REQ-025 start in RUN or DRAIN is ignored.
REQ-026 A sample is accepted when in_valid=1 and the state is RUN or DRAIN.
REQ-027 On acceptance, avg_valid=1 and avg_x=in_data registered, 1-cycle latency; otherwise avg_valid=0 and avg_x holds its previous value.
REQ-028 Block length L = 2^n; a cfg value of 0 is clamped to n=1.
REQ-029 A 7-bit sample counter increments per accepted sample and wraps to 0 after L samples, i.e. a block boundary.
REQ-030 At each boundary blk_cnt increments, wrapping at 0xFFFF.
REQ-031 cfg_wr in IDLE updates avg_n_avgs on the next edge.
REQ-032 cfg_wr in RUN or DRAIN stores a pending value; a later cfg_wr overwrites it (last write wins).
REQ-033 The pending value is applied on the edge where the counter wraps to 0.
REQ-034 cfg_wr with counter=0 and no sample accepted that cycle applies on the next edge.
REQ-035 cfg_wr with counter=0 while a sample is accepted that cycle stays pending, because the block already started with the old n.
REQ-036 avg_n_avgs never changes while the counter is nonzero.
REQ-037 stop in RUN with counter=0 and no sample accepted -> IDLE.
REQ-038 stop in RUN otherwise -> DRAIN.
REQ-039 DRAIN keeps accepting samples until the counter wraps, then -> IDLE on that edge; samples arriving in IDLE are dropped (avg_valid=0).
REQ-040 A stop while in DRAIN or IDLE is ignored.
REQ-041 Result buffer is one entry: avg_new_dat=1 loads avg_y into out_data and sets out_valid, on the next edge.
REQ-042 out_valid clears on the edge where out_valid & out_ready, unless a new avg_new_dat arrives in the same cycle, in which case the buffer reloads and out_valid stays 1.
REQ-043 avg_new_dat with out_valid=1 and out_ready=0: the new result is dropped, out_data is unchanged and ovf is set.
REQ-044 ovf is cleared only by reset or start.
REQ-045 Results keep draining after the return to IDLE; the buffer is not flushed by stop.

Reset
REQ-046 On rst_n=0 at a rising edge, all of the following load: state=IDLE; avg_valid=0; avg_x=0; avg_n_avgs=1; pending cleared; counter=0; blk_cnt=0; out_valid=0; out_data=0; ovf=0; busy=0.
REQ-047 Reset takes priority over every other input, including mid-run, and a pending config is discarded.

Verification
REQ-048 Reset test: rst_n=0 for 2 cycles with in_valid=1 and start=1 -> all outputs at reset values, avg_n_avgs=1.
REQ-049 Basic run test: cfg_wr n=2, start, samples 1..8 back-to-back -> 8 avg_valid pulses, each 1 cycle after the input; blk_cnt steps 1 then 2 after samples 4 and 8.
REQ-050 Mid-block config test: n=1 run, 1 sample accepted, cfg_wr n=3 -> avg_n_avgs stays 1 until the 2nd sample's wrap edge, then 3; the next boundary is reached after 8 further samples.
REQ-051 Stop test: n=2, stop after 3 samples -> busy stays 1 in DRAIN, the 4th sample is accepted, then IDLE; a 5th sample gives avg_valid=0.
REQ-052 Backpressure test: out_ready=0, avg_new_dat with avg_y=0x0010 then 0x0020 -> out_data=0x0010, ovf=1; out_ready=1 for one cycle -> out_valid=0.
REQ-053 Reset mid-run test: pending cfg n=5 in RUN, rst_n pulse -> IDLE, avg_n_avgs=1, and the next start runs with n=1.
